// File: rtl/prio_code_pkg.sv
// Shared types and decode helper for the 4-to-2 priority-code link.
// Used by the receive-side decoder and by encoder-side models.
package prio_code_pkg;

   localparam int CODE_W = 2;
   localparam int GNT_W  = 4;

   typedef struct packed {
      logic              none;
      logic [CODE_W-1:0] code;
   } entry_t;

   function automatic logic [GNT_W-1:0] code_to_onehot(input logic              none,
                                                       input logic [CODE_W-1:0] code);
      logic [GNT_W-1:0] onehot;
      onehot = '0;
      if (!none) begin
         case (code)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
         endcase
      end
      return onehot;
   endfunction

endpackage

// File: rtl/prio_code_fifo.sv
// Show-ahead FIFO of DEPTH entries with an occupancy output.
// The head entry is visible on out_data whenever out_valid is high.
module prio_code_fifo
   import prio_code_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  entry_t           in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output entry_t           out_data,
   output logic [LVL_W-1:0] level
);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push;
   logic               pop;

   assign in_ready  = (level != LVL_W'(DEPTH));
   assign out_valid = (level != '0);
   assign out_data  = mem[rd_ptr];

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // Pointers wrap naturally because DEPTH is a power of two.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; level and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/prio_code_decoder.sv
// Receive end of the priority-code link: buffers {none, code} entries and
// decodes the head to a one-hot grant, counting delivered grants (saturating).
module prio_code_decoder
   import prio_code_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CODE_W-1:0]          in_code,
   input  logic                       in_none,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [GNT_W-1:0]           out_onehot,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           grant_cnt
);

   entry_t in_entry;
   entry_t head;

   assign in_entry = '{none: in_none, code: in_code};

   prio_code_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head),
      .level     (level)
   );

   // NOTE: the output gets a default before any condition so no latch is inferred.
   always_comb begin
      out_onehot = '0;
      if (out_valid) out_onehot = code_to_onehot(head.none, head.code);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
      end else if (out_valid && out_ready && !head.none && (grant_cnt != '1)) begin
         grant_cnt <= grant_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prio_code_decoder.sv
// Randomized bench for prio_code_decoder against a queue-based reference model.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_prio_code_decoder;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [1:0] in_code;
   logic       in_none;
   logic       out_ready;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_onehot;
   logic [2:0] level;
   logic [7:0] grant_cnt;
   logic       in_ready4;
   logic       out_valid4;
   logic [3:0] out_onehot4;
   logic [2:0] level4;
   logic [3:0] grant_cnt4;

   int checks = 0;
   int errors = 0;

   logic [2:0] exp_q [$];
   int         exp_cnt;
   int         exp_cnt4;

   prio_code_decoder #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_none(in_none), .out_valid(out_valid),
      .out_ready(out_ready), .out_onehot(out_onehot), .level(level),
      .grant_cnt(grant_cnt)
   );

   prio_code_decoder #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_code(in_code), .in_none(in_none), .out_valid(out_valid4),
      .out_ready(out_ready), .out_onehot(out_onehot4), .level(level4),
      .grant_cnt(grant_cnt4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] exp_onehot();
      logic [2:0] e;
      if (exp_q.size() == 0) return 4'b0000;
      e = exp_q[0];
      if (e[2]) return 4'b0000;
      return 4'b0001 << e[1:0];
   endfunction

   // Drives one cycle of stimulus from a negedge and advances the model across the posedge.
   task automatic step(input logic v, input logic [1:0] c, input logic n, input logic r);
      logic       do_push;
      logic       do_pop;
      logic [2:0] hd;
      in_valid  = v;
      in_code   = c;
      in_none   = n;
      out_ready = r;
      do_push = v && (exp_q.size() < DEPTH);
      do_pop  = r && (exp_q.size() > 0);
      hd      = (exp_q.size() > 0) ? exp_q[0] : 3'b100;
      @(posedge clk);
      if (do_pop) begin
         exp_q.delete(0);
         if (!hd[2]) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt4 < 15) exp_cnt4++;
         end
      end
      if (do_push) exp_q.push_back({n, c});
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      exp_q.delete();
      exp_cnt  = 0;
      exp_cnt4 = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; in_none = 1'b0; out_ready = 1'b0;
      exp_q.delete(); exp_cnt = 0; exp_cnt4 = 0;
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (out_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot: got %b expected 0000", out_onehot); end
      checks++; if (grant_cnt !== 8'd0) begin errors++; $display("FAIL reset_grant_cnt: got %0d expected 0", grant_cnt); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      step(1'b1, 2'd2, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (out_onehot !== 4'b0100) begin errors++; $display("FAIL single_onehot: got %b expected 0100", out_onehot); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
      step(1'b0, 2'd0, 1'b0, 1'b1);
      checks++; if (grant_cnt !== 8'd1) begin errors++; $display("FAIL single_grant_cnt: got %0d expected 1", grant_cnt); end
   endtask

   task automatic test_fill_drain();
      logic [3:0] seq [4];
      seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};
      do_reset();
      step(1'b1, 2'd0, 1'b0, 1'b0);
      step(1'b1, 2'd1, 1'b0, 1'b0);
      step(1'b1, 2'd3, 1'b0, 1'b0);
      step(1'b1, 2'd2, 1'b1, 1'b0);
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", level); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
      step(1'b1, 2'd2, 1'b0, 1'b0);
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL refused_push_level: got %0d expected 4", level); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_onehot !== seq[i]) begin errors++; $display("FAIL drain_onehot[%0d]: got %b expected %b", i, out_onehot, seq[i]); end
         step(1'b0, 2'd0, 1'b0, 1'b1);
      end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", level); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
      checks++; if (grant_cnt !== 8'd3) begin errors++; $display("FAIL drain_grant_cnt: got %0d expected 3", grant_cnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 2'(i % 4), 1'b0, 1'b1);
         checks++; if (level !== 3'd1) begin errors++; $display("FAIL stream_level[%0d]: got %0d expected 1", i, level); end
         checks++; if (out_onehot !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL stream_onehot[%0d]: got %b expected %b", i, out_onehot, 4'b0001 << (i % 4)); end
         checks++; if (grant_cnt !== 8'(i)) begin errors++; $display("FAIL stream_grant_cnt[%0d]: got %0d expected %0d", i, grant_cnt, i); end
      end
      step(1'b0, 2'd0, 1'b0, 1'b1);
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL stream_final_level: got %0d expected 0", level); end
      checks++; if (grant_cnt !== 8'd20) begin errors++; $display("FAIL stream_final_cnt: got %0d expected 20", grant_cnt); end
   endtask

   task automatic test_random_backpressure();
      int         pushed = 0;
      int         cycles = 0;
      logic       v, n, r, prev_stall;
      logic [1:0] c;
      logic [3:0] prev_oh;
      do_reset();
      prev_stall = 1'b0;
      prev_oh    = 4'b0000;
      while ((pushed < 1000 || exp_q.size() > 0) && cycles < 20000) begin
         v = (pushed < 1000) && ($urandom_range(3) != 0);
         c = 2'($urandom_range(3));
         n = ($urandom_range(7) == 0);
         r = 1'($urandom_range(1));
         checks++; if (out_onehot !== exp_onehot()) begin errors++; $display("FAIL rand_onehot@%0d: got %b expected %b", cycles, out_onehot, exp_onehot()); end
         checks++; if (level !== 3'(exp_q.size())) begin errors++; $display("FAIL rand_level@%0d: got %0d expected %0d", cycles, level, exp_q.size()); end
         checks++; if (grant_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rand_grant_cnt@%0d: got %0d expected %0d", cycles, grant_cnt, exp_cnt); end
         if (prev_stall) begin
            checks++; if (out_onehot !== prev_oh) begin errors++; $display("FAIL rand_stall_stable@%0d: got %b expected %b", cycles, out_onehot, prev_oh); end
         end
         prev_stall = (exp_q.size() > 0) && !r;
         prev_oh    = out_onehot;
         if (v && exp_q.size() < DEPTH) pushed++;
         step(v, c, n, r);
         cycles++;
      end
      checks++;
      if (cycles >= 20000) begin errors++; $display("FAIL rand_timeout: got %0d entries pushed, %0d queued, expected 1000 and 0", pushed, exp_q.size()); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 2'($urandom_range(3)), 1'b0, 1'b1);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      checks++; if (grant_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_cnt4: got %h expected f", grant_cnt4); end
      checks++; if (grant_cnt !== 8'd20) begin errors++; $display("FAIL sat_cnt8: got %0d expected 20", grant_cnt); end
      for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 1'b0, 1'b1);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      checks++; if (grant_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_cnt4_hold: got %h expected f", grant_cnt4); end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b1, 2'd3, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 1'b0, 1'b0);
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL areset_pre_level: got %0d expected 3", level); end
      checks++; if (grant_cnt !== 8'd1) begin errors++; $display("FAIL areset_pre_cnt: got %0d expected 1", grant_cnt); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL areset_level: got %0d expected 0", level); end
      checks++; if (grant_cnt !== 8'd0) begin errors++; $display("FAIL areset_cnt: got %0d expected 0", grant_cnt); end
      checks++; if (out_onehot !== 4'b0000) begin errors++; $display("FAIL areset_onehot: got %b expected 0000", out_onehot); end
      in_valid = 1'b0;
      exp_q.delete(); exp_cnt = 0; exp_cnt4 = 0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 2'd1, 1'b0, 1'b0);
      checks++; if (out_onehot !== 4'b0010) begin errors++; $display("FAIL areset_after_onehot: got %b expected 0010", out_onehot); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL areset_after_level: got %0d expected 1", level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_random_backpressure();
      test_saturate();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_code_decoder.md
Name: prio_code_decoder

Overview:
- Receive end of the 4-to-2 priority-encoder link: accepts 2-bit request codes plus a "none" flag over a valid/ready handshake.
- Buffers codes in a small FIFO and decodes each one back to a 4-bit one-hot grant vector on a valid/ready output.
- Sits between the encoder stage and downstream grant consumers, and absorbs consumer backpressure.
- Maintains a saturating count of delivered grants for debug.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of delivered-grant counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a code.
- in_ready  out  1  block can accept a code.
- in_code  in  2  encoded index 0..3.
- in_none  in  1  no request active; in_code is ignored when set.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head entry.
- out_onehot  out  4  decoded grant vector.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- grant_cnt  out  CNT_W  saturating count of non-none entries popped.

Behaviour:
- Reset, asynchronous: level=0, out_valid=0, in_ready=1, out_onehot=4'b0000, grant_cnt=0, read/write pointers=0. Storage contents are don't-care.
- Push: in_valid && in_ready at a clk edge. Entry {in_none, in_code} is written at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready at a clk edge. rd_ptr increments modulo DEPTH.
- in_ready = (level != DEPTH), combinational from registered level. No dependence on out_ready; no pass-through when full.
- out_valid = (level != 0).
- out_onehot is decoded combinationally from the head entry:
  - none=1 -> 4'b0000
  - code 0 -> 4'b0001, code 1 -> 4'b0010, code 2 -> 4'b0100, code 3 -> 4'b1000
  - out_onehot = 4'b0000 whenever out_valid=0.
- Latency: a code pushed into an empty FIFO at edge N gives out_valid=1 after edge N. The head is visible in the cycle after acceptance (1-cycle latency).
- Level update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Simultaneous push and pop are legal at any level 1..DEPTH-1. At level 0 only a push can occur; at level DEPTH only a pop can occur.
- Pointers wrap from DEPTH-1 to 0 with no bubble. FIFO ordering is strict.
- grant_cnt increments by 1 on each pop of an entry with none=0. It holds at all-ones (saturates) and never wraps.
- Output stability: while out_valid=1 and out_ready=0, out_onehot is held stable.
- Reset mid-operation: all queued entries are discarded, and outputs return to their reset values immediately (asynchronous).
- Every combinational decode path covers all input values, including a default branch. No storage element is inferred outside the clocked process.

Decomposition:
- Shared package prio_code_pkg:
  - CODE_W=2 and GNT_W=4 constants.
  - Entry typedef {none, code}.
  - Function code_to_onehot(none, code), shared with the encoder-side bench model.
- One sub-module: prio_code_fifo, a generic DEPTH x entry show-ahead FIFO with level output.
- Top level holds the decode and grant_cnt.

Test Plan:
- Reset, then push code=2 none=0 with out_ready=0 -> next cycle: out_valid=1, out_onehot=4'b0100, level=1, in_ready=1.
- Push codes 0,1,3,none back-to-back with out_ready=0 -> level=4, in_ready=0; a fifth push is refused. Then hold out_ready=1 -> outputs 0001, 0010, 1000, 0000 in order; level returns to 0; grant_cnt=3.
- Steady streaming, in_valid=1 and out_ready=1 for 20 cycles with codes cycling 0..3 -> level stays 1 after fill and one code is delivered per cycle. Pointer wrap shows no duplicate or lost entry.
- Random backpressure, out_ready toggling pseudo-randomly, 1000 codes -> output sequence matches a scoreboard and out_onehot is stable while stalled.
- With CNT_W=4, pop 20 non-none entries -> grant_cnt reads 4'hF and stays there.
- Assert rst asynchronously mid-cycle with level=3 -> out_valid=0, level=0, grant_cnt=0, and out_onehot=0 before the next clk edge. A new push afterwards is delivered correctly.
